ssb_sync_tracker: RTL
=====================

# ssb_sync_tracker

Multi-channel SSB timing controller placed between the per-N_id_2 PSS peak detectors and the FFT/FFT_demod stage. In SEARCH it accepts a peak from any correlator channel and latches the winning N_id_2. It then skips the remaining cyclic prefix and gates the FFT input over the data portion of each following SSB symbol (PBCH, SSS, PBCH). After the burst it tracks the next SSB inside a window around the expected period, flywheeling through missed peaks until a miss limit returns it to SEARCH.

## Interface
- N_CH, 3: number of correlator/peak-detector channels (1..3); channel index = N_id_2
- SCORE_DW, 32: width of each channel's peak score
- FFT_LEN, 256: data samples per symbol
- CP_LEN, 18: cyclic prefix samples per symbol
- DETECTION_DELAY, 15: samples from PSS end to peak pulse; must be ≤ CP_LEN
- NUM_SYMBOLS, 4: SSB symbols including PSS; demodulated symbols are 1..NUM_SYMBOLS-1
- PERIOD_LEN, 4800: valid samples between consecutive SSB peaks; must exceed (NUM_SYMBOLS-1)*(FFT_LEN+CP_LEN)+TRACK_WIN
- TRACK_WIN, 8: ± tracking window, in samples (inclusive)
- MAX_MISSES, 3: consecutive missed peaks before returning to SEARCH (≥1)
- clk_i  in  1  sample clock; the block's only clock
- reset_i  in  1  synchronous, active-high reset
- s_axis_in_tvalid  in  1  sample strobe; all sample counters advance only when it is high
- peak_detected_i  in  N_CH  one-cycle peak pulse per channel
- peak_score_i  in  N_CH*SCORE_DW  per-channel score; channel k occupies bits [k*SCORE_DW +: SCORE_DW]
- fft_enable_o  out  1  high over the data samples of each demodulated symbol; consumers use s_axis_in_tvalid && fft_enable_o
- symbol_start_o  out  1  one-cycle pulse coinciding with the first data sample of each symbol
- symbol_idx_o  out  2  index of the current/last symbol (1..NUM_SYMBOLS-1)
- N_id_2_o  out  2  latched channel index
- locked_o  out  1  high from the first accepted peak until the miss limit is reached
- state_debug_o  out  2  SEARCH=0, ALIGN=1, DEMOD=2, TRACK=3

## Operation
- SEARCH: wait for any bit of peak_detected_i. If several bits are set in the same cycle, pick the highest score; ties go to the lowest index. Latch N_id_2_o, set locked_o, clear miss_cnt, zero period_cnt, go to ALIGN.
- ALIGN: count WAIT = CP_LEN-DETECTION_DELAY valid samples, then enter DEMOD with symbol_idx=1. If WAIT=0, DEMOD starts on the next valid sample.
- DEMOD: fft_enable_o is high for FFT_LEN valid samples, then low for CP_LEN valid samples; symbol_idx then increments. After the data phase of symbol NUM_SYMBOLS-1, go to TRACK without waiting for its trailing CP.
- TRACK: the window is period_cnt in [PERIOD_LEN-TRACK_WIN, PERIOD_LEN+TRACK_WIN].
  - A peak on the latched channel inside the window: treat as accepted (zero period_cnt, clear miss_cnt, go to ALIGN).
  - Peaks on other channels, and peaks outside the window, are ignored.
  - If period_cnt passes PERIOD_LEN+TRACK_WIN without a peak, increment miss_cnt. If miss_cnt reaches MAX_MISSES: clear locked_o, go to SEARCH. Otherwise flywheel: go to ALIGN with period_cnt = TRACK_WIN+1, i.e. anchored at the expected position PERIOD_LEN.
- peak_detected_i is ignored in ALIGN and DEMOD.
- period_cnt runs on valid samples in every state except SEARCH. Its width is $clog2(PERIOD_LEN+TRACK_WIN+2); it never wraps.
- Score comparison is unsigned.

## Timing
- All outputs are registered. Reset value is 0 for every output and every counter; the state resets to SEARCH.
- reset_i asserted mid-burst: on the next edge all outputs are 0 and the state is SEARCH, regardless of state.
- Continuous tvalid, peak accepted at cycle t:
  - fft_enable_o is high for cycles t+WAIT+1 … t+WAIT+FFT_LEN.
  - symbol_start_o pulses at t+WAIT+1.
  - The next symbol starts at t+WAIT+1+FFT_LEN+CP_LEN.
- With gaps in tvalid, every transition happens on the cycle after the counting valid sample. fft_enable_o holds its value through gaps.
- N_id_2_o and locked_o update on the cycle after acceptance (t+1). locked_o falls on the cycle after the final miss.

## Test plan
- Channel-1 peak at t=100 with continuous tvalid and defaults (WAIT=3) -> fft_enable_o high for cycles 104..359 (256 cycles); symbol_start_o at 104, 378 and 652 with idx 1, 2, 3; N_id_2_o=1 and locked_o=1 from cycle 101.
- Simultaneous peaks on channels 0 and 2 with scores 500 and 900 -> N_id_2_o=2. Equal scores of 700 -> N_id_2_o=0.
- Locked with peaks at period_cnt 4792, 4808 and 4809 -> the first two re-arm ALIGN; 4809 falls outside the window and counts as a miss with flywheel ALIGN. A channel-0 peak inside the window while locked to channel 1 is ignored.
- Three consecutive windows with no peak -> two flywheel bursts are still generated; locked_o drops and state returns to SEARCH one cycle after the third window closes.
- tvalid toggling 1/0 every cycle -> fft_enable_o spans exactly 256 valid samples per symbol and symbol spacing is 274 valid samples.
- reset_i pulsed while fft_enable_o=1 in symbol 2 -> on the next cycle all outputs are 0 and state_debug_o=0. A subsequent peak re-locks normally.

Source files
------------

// File: rtl/ssb_sync_tracker.sv
// SSB timing controller between the per-N_id_2 PSS peak detectors and the FFT stage.
// Latches the winning channel, gates FFT input over each SSB data symbol and tracks the burst period.
//
// state  | meaning
// SEARCH | unlocked, waiting for a peak on any channel
// ALIGN  | skipping the remainder of the PSS cyclic prefix
// DEMOD  | gating the data portion of symbols 1..NUM_SYMBOLS-1
// TRACK  | waiting for the next peak inside the period window
module ssb_sync_tracker #(
  parameter int N_CH            = 3,
  parameter int SCORE_DW        = 32,
  parameter int FFT_LEN         = 256,
  parameter int CP_LEN          = 18,
  parameter int DETECTION_DELAY = 15,
  parameter int NUM_SYMBOLS     = 4,
  parameter int PERIOD_LEN      = 4800,
  parameter int TRACK_WIN       = 8,
  parameter int MAX_MISSES      = 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     s_axis_in_tvalid,
  input  logic [N_CH-1:0]          peak_detected_i,
  input  logic [N_CH*SCORE_DW-1:0] peak_score_i,
  output logic                     fft_enable_o,
  output logic                     symbol_start_o,
  output logic [1:0]               symbol_idx_o,
  output logic [1:0]               N_id_2_o,
  output logic                     locked_o,
  output logic [1:0]               state_debug_o
);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] ALIGN  = 2'd1;
  localparam logic [1:0] DEMOD  = 2'd2;
  localparam logic [1:0] TRACK  = 2'd3;

  localparam int WAIT   = CP_LEN - DETECTION_DELAY;
  localparam int PCNT_W = $clog2(PERIOD_LEN + TRACK_WIN + 2);
  localparam int SYM_W  = $clog2(FFT_LEN + CP_LEN + 1);
  localparam int WAIT_W = (WAIT > 1) ? $clog2(WAIT) : 1;
  localparam int MISS_W = $clog2(MAX_MISSES + 1);

  localparam logic [PCNT_W-1:0] WIN_LO    = PCNT_W'(PERIOD_LEN - TRACK_WIN);
  localparam logic [PCNT_W-1:0] WIN_HI    = PCNT_W'(PERIOD_LEN + TRACK_WIN);
  localparam logic [PCNT_W-1:0] PCNT_MAX  = PCNT_W'(PERIOD_LEN + TRACK_WIN + 1);
  localparam logic [PCNT_W-1:0] FLY_CNT   = PCNT_W'(TRACK_WIN + 1);
  localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);
  localparam logic [SYM_W-1:0]  DATA_TC   = SYM_W'(FFT_LEN - 1);
  localparam logic [SYM_W-1:0]  CP_TC     = SYM_W'((CP_LEN > 0) ? CP_LEN - 1 : 0);
  localparam logic [SYM_W-1:0]  SYM_ONE   = SYM_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((WAIT > 0) ? WAIT - 1 : 0);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MAX_MISSES - 1);
  localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);
  localparam logic [1:0]        LAST_SYM  = 2'(NUM_SYMBOLS - 1);
  localparam logic [1:0]        ARM_STATE = (WAIT == 0) ? DEMOD : ALIGN;

  logic [1:0]          state, state_nxt;
  logic [PCNT_W-1:0]   period_cnt;
  logic [SYM_W-1:0]    sym_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [MISS_W-1:0]   miss_cnt;

  logic                pick_valid;
  logic [1:0]          pick_idx;
  logic [SCORE_DW-1:0] pick_score;
  logic                own_peak;
  logic                in_window;
  logic                accept, miss, lose, arm;
  logic                align_done, sym_tc, data_end, first_sym, begin_sym;

  // Strict greater-than while scanning upward keeps ties on the lowest index.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 2'd0;
    pick_score = '0;
    own_peak   = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (peak_detected_i[k] &&
          (!pick_valid || (peak_score_i[k*SCORE_DW +: SCORE_DW] > pick_score))) begin
        pick_valid = 1'b1;
        pick_idx   = 2'(k);
        pick_score = peak_score_i[k*SCORE_DW +: SCORE_DW];
      end
      if (peak_detected_i[k] && (N_id_2_o == 2'(k))) begin
        own_peak = 1'b1;
      end
    end
  end

  assign in_window  = (period_cnt >= WIN_LO) && (period_cnt <= WIN_HI);
  assign accept     = ((state == SEARCH) && pick_valid) ||
                      ((state == TRACK) && own_peak && in_window);
  assign miss       = (state == TRACK) && !accept && (period_cnt == PCNT_MAX);
  assign lose       = miss && (miss_cnt == MISS_LAST);
  assign arm        = accept || (miss && !lose);

  assign align_done = (state == ALIGN) && s_axis_in_tvalid && (wait_cnt == '0);
  assign sym_tc     = (state == DEMOD) && s_axis_in_tvalid && (sym_cnt == '0);
  assign data_end   = sym_tc && fft_enable_o;
  assign first_sym  = align_done || (arm && (WAIT == 0));
  // With no cyclic prefix the next symbol follows its predecessor's data directly.
  assign begin_sym  = first_sym || (sym_tc && !fft_enable_o) ||
                      (data_end && (CP_LEN == 0) && (symbol_idx_o != LAST_SYM));

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH: if (arm) state_nxt = ARM_STATE;
      ALIGN:  if (align_done) state_nxt = DEMOD;
      DEMOD:  if (data_end && (symbol_idx_o == LAST_SYM)) state_nxt = TRACK;
      TRACK: begin
        if (lose)     state_nxt = SEARCH;
        else if (arm) state_nxt = ARM_STATE;
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state          <= SEARCH;
      period_cnt     <= '0;
      sym_cnt        <= '0;
      wait_cnt       <= '0;
      miss_cnt       <= '0;
      fft_enable_o   <= 1'b0;
      symbol_start_o <= 1'b0;
      symbol_idx_o   <= 2'd0;
      N_id_2_o       <= 2'd0;
      locked_o       <= 1'b0;
    end else begin
      state          <= state_nxt;
      symbol_start_o <= begin_sym;

      if ((state == SEARCH) && pick_valid) begin
        N_id_2_o <= pick_idx;
      end

      if (accept) begin
        locked_o <= 1'b1;
        miss_cnt <= '0;
      end else if (miss) begin
        miss_cnt <= miss_cnt + MISS_ONE;
        if (lose) locked_o <= 1'b0;
      end

      // A flywheel restarts the count as if the peak had arrived at PERIOD_LEN.
      if (accept) begin
        period_cnt <= '0;
      end else if (miss) begin
        period_cnt <= FLY_CNT;
      end else if ((state != SEARCH) && s_axis_in_tvalid && (period_cnt != PCNT_MAX)) begin
        period_cnt <= period_cnt + PCNT_ONE;
      end

      if (arm) begin
        wait_cnt <= WAIT_LOAD;
      end else if ((state == ALIGN) && s_axis_in_tvalid && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - WAIT_ONE;
      end

      if (begin_sym) begin
        fft_enable_o <= 1'b1;
        sym_cnt      <= DATA_TC;
        symbol_idx_o <= first_sym ? 2'd1 : symbol_idx_o + 2'd1;
      end else if (data_end) begin
        fft_enable_o <= 1'b0;
        sym_cnt      <= CP_TC;
      end else if ((state == DEMOD) && s_axis_in_tvalid && (sym_cnt != '0)) begin
        sym_cnt <= sym_cnt - SYM_ONE;
      end
    end
  end

  assign state_debug_o = state;

endmodule
